receptor_adc: RTL and testbench
===============================

RECEPTOR_ADC -- requirements
Module: receptor_adc

Interface
REQ-001 Parameter N, default 19, total width of signed fixed-point sample (matches `N in constantes.h).
REQ-002 Parameter F, default 10; ADC sample width is F-1 bits (matches `F in constantes.h).
REQ-003 Parameter DIV, default 4, clk cycles per SCLK half-period, DIV >= 2.
REQ-004 Parameter FRAME, default 16, SCLK periods per conversion frame.
REQ-005 Parameter LEAD, default 3, leading non-data bits per frame; LEAD+(F-1) <= FRAME.
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 Inicio  input  1  start-conversion request, sampled only in IDLE.
REQ-009 SDATA  input  1  serial data from ADC, MSB first, offset binary.
REQ-010 CS  output  1  ADC chip select, active low, registered.
REQ-011 SCLK  output  1  ADC serial clock, idle high, registered.
REQ-012 Dato_Out  output  N  signed two's-complement fixed-point sample, F-2 fractional-aligned bits.
REQ-013 Listo  output  1  one-cycle strobe, Dato_Out updated this cycle.
REQ-014 Ocupado  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ARRANQUE, TRANS, FIN, PAUSA.
REQ-016 IDLE: CS=1, SCLK=1; Inicio=1 -> ARRANQUE next cycle with CS=0.
REQ-017 ARRANQUE: CS=0, SCLK=1 for DIV cycles (CS setup), then -> TRANS.
REQ-018 TRANS: FRAME SCLK periods, each SCLK=0 for DIV cycles then SCLK=1 for DIV cycles; CS=0 throughout.
REQ-019 SDATA SHALL be shifted in on the clk cycle SCLK goes 0->1; bit index k=0..FRAME-1 counted per rising SCLK.
REQ-020 Bits k<LEAD and k>=LEAD+F-1 SHALL be discarded; bits LEAD..LEAD+F-2 form sample u[F-2:0], MSB first.
REQ-021 After last SCLK high phase -> FIN: CS=1, SCLK=1, Dato_Out loaded, Listo=1 for exactly one cycle.
REQ-022 Conversion: Dato_Out[N-1:F-2] = replicated ~u[F-2]; Dato_Out[F-3:0] = u[F-3:0].
REQ-023 Conversion SHALL be exact inverse of the DAC-side truncation for non-saturated values; no rounding or saturation.
REQ-024 FIN -> PAUSA: CS=1, SCLK=1 for 2*DIV cycles (ADC quiet time), then -> IDLE.
REQ-025 Latency: Inicio sampled at cycle t -> Listo=1 at cycle t+1+DIV+2*DIV*FRAME (t+133 at defaults).
REQ-026 Minimum start-to-start interval: 2+DIV+2*DIV*FRAME+2*DIV cycles (142 at defaults).
REQ-027 Inicio while Ocupado=1 SHALL be ignored, not queued; Inicio held high in IDLE starts back-to-back frames.
REQ-028 Dato_Out SHALL hold its value between Listo strobes; Listo never asserted outside FIN.
REQ-029 SCLK and CS SHALL be glitch-free register outputs; SCLK never toggles while CS=1.

Reset
REQ-030 reset=1 at any clock edge SHALL force IDLE, CS=1, SCLK=1, Listo=0, Dato_Out=0, bit and divider counters 0.
REQ-031 Reset mid-frame SHALL abort the frame with no Listo and no Dato_Out update other than clearing to 0.
REQ-032 reset has priority over Inicio in the same cycle.

Verification
REQ-033 ADC model returns u=9'h100, Inicio pulse -> Listo at t+133, Dato_Out=19'h00000.
REQ-034 u=9'h1FF -> Dato_Out=19'h000FF; u=9'h000 -> Dato_Out=19'h7FF00; u=9'h0FF -> Dato_Out=19'h7FFFF.
REQ-035 Leading bits driven 1 and trailing bits driven 1 with u=9'h0AA -> Dato_Out=19'h7FFAA (non-data bits ignored).
REQ-036 Inicio pulsed at t+10 and t+140 after a start at t -> only one frame, second start ignored; CS stays low exactly 1+DIV+2*DIV*FRAME-1 cycles, SCLK shows 16 low pulses of 4 cycles.
REQ-037 reset asserted at 8th SCLK rising edge -> next cycle CS=1, SCLK=1, Dato_Out=0, no Listo; subsequent Inicio completes a normal frame.
REQ-038 Round trip: each of 512 codes through receptor_adc then DAC-side truncation -> original 9-bit code reproduced.

Source files
------------

// File: rtl/receptor_adc.sv
// Serial ADC front end: runs one CS/SCLK conversion frame per start request and converts the
// offset-binary sample into a signed fixed-point word.
module receptor_adc #(
    parameter int N     = 19,
    parameter int F     = 10,
    parameter int DIV   = 4,
    parameter int FRAME = 16,
    parameter int LEAD  = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Inicio,
    input  logic         SDATA,
    output logic         CS,
    output logic         SCLK,
    output logic [N-1:0] Dato_Out,
    output logic         Listo,
    output logic         Ocupado
);

    localparam int UW = F - 1;
    localparam int CW = $clog2(2 * DIV);
    localparam int BW = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PER_LAST  = CW'(2 * DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME - 1);
    localparam logic [BW-1:0] DATA_LO   = BW'(LEAD);
    localparam logic [BW-1:0] DATA_HI   = BW'(LEAD + UW - 1);

    typedef enum logic [2:0] {IDLE, ARRANQUE, TRANS, FIN, PAUSA} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [UW-1:0]   sh_q, sh_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            listo_q, listo_d;
    logic [N-1:0]    dato_q, dato_d;

    // Output registers are loaded with the values belonging to the next state, so CS/SCLK/Listo
    // are clean flops that line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        listo_d = 1'b0;
        dato_d  = dato_q;

        unique case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                cnt_d  = '0;
                bit_d  = '0;
                if (Inicio) begin
                    state_d = ARRANQUE;
                    cs_d    = 1'b0;
                end
            end
            ARRANQUE: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = TRANS;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRANS: begin
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = FIN;
                        cs_d    = 1'b1;
                        sclk_d  = 1'b1;
                        listo_d = 1'b1;
                        bit_d   = '0;
                        // Offset binary to two's complement: invert MSB and sign-extend it.
                        dato_d  = {{(N - UW + 1){~sh_q[UW-1]}}, sh_q[UW-2:0]};
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == HALF_LAST) begin
                        sclk_d = 1'b1;
                        if (bit_q >= DATA_LO && bit_q <= DATA_HI) begin
                            sh_d = {sh_q[UW-2:0], SDATA};
                        end
                    end
                end
            end
            FIN: begin
                state_d = PAUSA;
                cnt_d   = '0;
            end
            PAUSA: begin
                if (cnt_q == PER_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            listo_q <= 1'b0;
            dato_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            listo_q <= listo_d;
            dato_q  <= dato_d;
        end
    end

    assign CS       = cs_q;
    assign SCLK     = sclk_q;
    assign Listo    = listo_q;
    assign Dato_Out = dato_q;
    assign Ocupado  = (state_q != IDLE);

endmodule

// File: tb/tb_receptor_adc.sv
// Bench for receptor_adc: behavioural serial ADC, scoreboard of expected samples popped on Listo,
// plus directed frame-timing, ignored-start and mid-frame reset scenarios.
module tb_receptor_adc;

    localparam int N     = 19;
    localparam int F     = 10;
    localparam int DIV   = 4;
    localparam int FRAME = 16;
    localparam int LEAD  = 3;
    localparam int LAT   = 1 + DIV + 2 * DIV * FRAME;
    localparam int CSLOW = DIV + 2 * DIV * FRAME;
    localparam int STEP  = 2 + DIV + 2 * DIV * FRAME + 2 * DIV;

    logic         clk = 1'b0;
    logic         reset;
    logic         Inicio;
    logic         SDATA;
    logic         CS;
    logic         SCLK;
    logic [N-1:0] Dato_Out;
    logic         Listo;
    logic         Ocupado;

    always #5 clk = ~clk;

    receptor_adc #(.N(N), .F(F), .DIV(DIV), .FRAME(FRAME), .LEAD(LEAD)) dut (
        .clk     (clk),
        .reset   (reset),
        .Inicio  (Inicio),
        .SDATA   (SDATA),
        .CS      (CS),
        .SCLK    (SCLK),
        .Dato_Out(Dato_Out),
        .Listo   (Listo),
        .Ocupado (Ocupado)
    );

    typedef struct {
        logic [N-1:0] dato;
        logic [8:0]   code;
        int           t0;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Offset binary code minus midscale, as a signed N-bit value.
    function automatic logic [N-1:0] model(input logic [8:0] u);
        int v;
        v = int'(u) - 256;
        return N'(v);
    endfunction

    // ADC: bit k (k = SCLK rises so far) presented during the low phase before rise k.
    logic [FRAME-1:0] frame_bits;
    int               k = 0;
    logic             adc_prev = 1'b1;
    always @(negedge clk) begin
        if (CS !== 1'b0) k = 0;
        else if (SCLK === 1'b1 && adc_prev === 1'b0) k++;
        adc_prev = SCLK;
        SDATA = (k < FRAME) ? frame_bits[k] : 1'b0;
    end

    int   listo_cnt = 0;
    int   cs_low = 0;
    int   rises = 0;
    int   bad_runs = 0;
    int   low_run = 0;
    logic mon_prev = 1'b1;
    always @(negedge clk) begin
        if (CS === 1'b0) cs_low++;
        if (reset === 1'b0 && SCLK !== mon_prev) chk("sclk_toggle_cs_low", 32'(CS), 32'd0);
        if (SCLK === 1'b0) low_run++;
        if (SCLK === 1'b1 && mon_prev === 1'b0) begin
            rises++;
            if (low_run != DIV) bad_runs++;
            low_run = 0;
        end
        mon_prev = SCLK;
        if (Listo === 1'b1) begin
            listo_cnt++;
            if (sb.size() == 0) begin
                chk("listo_unexpected", 32'(Listo), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("dato", 32'(Dato_Out), 32'(e.dato));
                chk("latency", 32'(cyc - e.t0), 32'(LAT));
                chk("roundtrip", 32'({~Dato_Out[F-2], Dato_Out[F-3:0]}), 32'(e.code));
            end
        end
    end

    task automatic set_frame(input logic [8:0] u, input logic fill);
        frame_bits = fill ? '1 : '0;
        for (int i = 0; i < F - 1; i++) frame_bits[LEAD+i] = u[F-2-i];
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (Ocupado !== 1'b0 && n < bound);
        chk("idle_reached", 32'(Ocupado), 32'd0);
        chk("no_pending_sample", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_frame(input logic [8:0] u, input logic fill);
        set_frame(u, fill);
        @(negedge clk);
        sb.push_back('{dato: model(u), code: u, t0: cyc});
        Inicio = 1'b1;
        @(negedge clk);
        Inicio = 1'b0;
        wait_idle(STEP + 20);
    endtask

    int t0, l0, c0, r0, b0, n;

    initial begin
        reset      = 1'b1;
        Inicio     = 1'b0;
        frame_bits = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(CS), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd1);
        chk("rst_listo", 32'(Listo), 32'd0);
        chk("rst_dato", 32'(Dato_Out), 32'd0);
        chk("rst_ocupado", 32'(Ocupado), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(9'h100, 1'b0);
        chk("mid_zero", 32'(Dato_Out), 32'h00000);
        run_frame(9'h1FF, 1'b0);
        chk("max_pos", 32'(Dato_Out), 32'h000FF);
        run_frame(9'h000, 1'b0);
        chk("max_neg", 32'(Dato_Out), 32'h7FF00);
        run_frame(9'h0FF, 1'b0);
        chk("minus_one", 32'(Dato_Out), 32'h7FFFF);
        run_frame(9'h0AA, 1'b1);
        chk("nondata_ignored", 32'(Dato_Out), 32'h7FFAA);
        repeat (20) @(negedge clk);
        chk("dato_hold", 32'(Dato_Out), 32'h7FFAA);

        // Extra starts during the frame and in the quiet time must be dropped.
        set_frame(9'h123, 1'b0);
        l0 = listo_cnt; c0 = cs_low; r0 = rises; b0 = bad_runs;
        @(negedge clk);
        t0 = cyc;
        sb.push_back('{dato: model(9'h123), code: 9'h123, t0: t0});
        Inicio = 1'b1;
        @(negedge clk);
        Inicio = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        Inicio = 1'b1;
        @(negedge clk);
        Inicio = 1'b0;
        while (cyc < t0 + 140) @(negedge clk);
        Inicio = 1'b1;
        @(negedge clk);
        Inicio = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignored_one_listo", 32'(listo_cnt - l0), 32'd1);
        chk("cs_low_cycles", 32'(cs_low - c0), 32'(CSLOW));
        chk("sclk_pulses", 32'(rises - r0), 32'(FRAME));
        chk("sclk_low_width", 32'(bad_runs - b0), 32'd0);
        chk("ignored_not_queued", 32'(Ocupado), 32'd0);
        chk("ignored_sb_empty", 32'(sb.size()), 32'd0);

        // Inicio held high: back-to-back frames at the minimum interval.
        set_frame(9'h05A, 1'b0);
        @(negedge clk);
        t0 = cyc;
        sb.push_back('{dato: model(9'h05A), code: 9'h05A, t0: t0});
        sb.push_back('{dato: model(9'h05A), code: 9'h05A, t0: t0 + STEP});
        Inicio = 1'b1;
        repeat (STEP + 3) @(negedge clk);
        Inicio = 1'b0;
        wait_idle(STEP + 20);

        // Reset right after the 8th SCLK rise aborts the frame.
        set_frame(9'h1C3, 1'b0);
        l0 = listo_cnt; r0 = rises;
        @(negedge clk);
        Inicio = 1'b1;
        @(negedge clk);
        Inicio = 1'b0;
        n = 0;
        while (rises - r0 < 8 && n < STEP) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_at_rise8", 32'(rises - r0), 32'd8);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs", 32'(CS), 32'd1);
        chk("abort_sclk", 32'(SCLK), 32'd1);
        chk("abort_dato", 32'(Dato_Out), 32'd0);
        chk("abort_listo", 32'(Listo), 32'd0);
        chk("abort_ocupado", 32'(Ocupado), 32'd0);
        reset = 1'b0;
        repeat (STEP) @(negedge clk);
        chk("abort_no_listo", 32'(listo_cnt - l0), 32'd0);
        chk("abort_dato_kept", 32'(Dato_Out), 32'd0);
        run_frame(9'h1C3, 1'b0);
        chk("after_abort", 32'(Dato_Out), 32'h000C3);

        for (int c = 0; c < 512; c++) run_frame(9'(c), c[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
